io_input_cond: RTL and testbench
================================

IO_INPUT_COND -- requirements
Module: io_input_cond

Interface
REQ-001 Parameter TICK_DIV, default 50000: system clocks per debounce sample tick; legal range 1..65535.
REQ-002 Parameter STABLE_TICKS, default 4: consecutive mismatching ticks needed to accept a new level; legal range 1..15.
REQ-003 Parameter BTN_ACTIVE_LOW, default 1: when 1, raw button inputs are inverted before synchronization.
REQ-004 i_clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 i_sw_raw  input  32  asynchronous board switches.
REQ-007 i_btn_raw  input  4  asynchronous board push-buttons.
REQ-008 o_sw  output  32  debounced switch levels; feeds CPU i_io_sw.
REQ-009 o_btn  output  4  debounced buttons, active-high = pressed; feeds CPU i_io_btn.
REQ-010 o_btn_press  output  4  one-cycle pulse per bit on debounced 0->1.
REQ-011 o_btn_release  output  4  one-cycle pulse per bit on debounced 1->0.
REQ-012 o_sw_chg  output  1  one-cycle pulse when any o_sw bit changes.

Function
REQ-013 36 independent channels (32 sw + 4 btn), identical behaviour; btn bits pass through the BTN_ACTIVE_LOW inversion first.
REQ-014 Each channel: 2-flop synchronizer (s1 <= raw, s2 <= s1); only s2 feeds later logic.
REQ-015 Shared prescaler: counts 0..TICK_DIV-1, wraps to 0; tick = 1 for exactly the cycle in which the count equals TICK_DIV-1; TICK_DIV=1 means tick every cycle.
REQ-016 Per-channel state: debounced level deb and mismatch counter cnt, 4 bits.
REQ-017 s2 == deb: cnt <= 0 on every cycle, tick or not.
REQ-018 s2 != deb and tick and cnt == STABLE_TICKS-1: deb <= s2 and cnt <= 0.
REQ-019 s2 != deb and tick and cnt < STABLE_TICKS-1: cnt <= cnt+1.
REQ-020 s2 != deb and no tick: cnt holds.
REQ-021 A glitch that returns before acceptance clears cnt (REQ-017); deb never changes.
REQ-022 Latency with TICK_DIV=1: a raw step held stable reaches o_sw/o_btn on the (2+STABLE_TICKS)th rising edge after the step.
REQ-023 o_sw and o_btn are registered and equal deb directly; no combinational path from raw inputs to any output.
REQ-024 o_btn_press[i] = 1 for exactly the cycle after deb goes 0->1; o_btn_release[i] likewise for 1->0; both registered.
REQ-025 o_sw_chg = 1 for exactly the cycle after any sw deb bit changes; simultaneous changes of several bits give a single pulse.
REQ-026 Channels are fully independent: simultaneous events on different bits are each handled per REQ-017..020 in the same cycle.

Reset
REQ-027 While rst=0 at a clock edge: all s1/s2/deb/cnt and the prescaler <= 0; all outputs 0, including o_btn (released).
REQ-028 Reset asserted mid-count discards partial counts; after release, channels restart from deb=0.
REQ-029 A raw level that is active at reset release is accepted via the normal debounce path; no press pulse occurs during reset.

Structure
REQ-030 Shared package io_cond_pkg: N_SW=32, N_BTN=4, CNT_W=4, default TICK_DIV/STABLE_TICKS values.
REQ-031 Sub-module db_channel (ports i_clk, rst, i_tick, i_raw, o_deb) implements REQ-014/016..021; generate 36 instances.
REQ-032 Prescaler, inversion and pulse generation live in io_input_cond.

Verification (TICK_DIV=1, STABLE_TICKS=4 unless stated)
REQ-033 Step i_sw_raw 0 -> 32'h0000_00A5 and hold -> o_sw = 32'h0000_00A5 on the 6th edge; o_sw_chg pulses once, 1 cycle.
REQ-034 i_btn_raw[0] high-low-high pulse 2 cycles wide (BTN_ACTIVE_LOW=1) -> o_btn stays 0, no press or release pulse.
REQ-035 i_btn_raw[2] held low 10 cycles, then high -> o_btn[2] rises on edge 6, o_btn_press[2] pulses once; release pulses once, 6 edges after the rising raw edge.
REQ-036 TICK_DIV=5: raw step -> output changes only after 4 ticks (edges 2+4*5 window); tick high exactly 1 of every 5 cycles.
REQ-037 rst=0 for 1 cycle while sw bit 3 is mid-count (cnt=2) -> all outputs 0 next cycle; bit 3 re-qualifies a full 6 edges after release.
REQ-038 Bits 0 and 31 of sw toggled in the same cycle -> both update on the same edge; a single o_sw_chg pulse.

Source files
------------

// File: rtl/io_cond_pkg.sv
// Shared sizes and defaults for the board input conditioning block.
// Switch channels sit in the low bits of the combined channel vector; buttons sit above them.
package io_cond_pkg;

  localparam int N_SW             = 32;
  localparam int N_BTN            = 4;
  localparam int N_CH             = N_SW + N_BTN;
  localparam int CNT_W            = 4;
  localparam int PRE_W            = 16;
  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 4;

endpackage

// File: rtl/io_input_cond_db_channel.sv
// One debounce channel: a two-flop synchronizer, then a tick-qualified mismatch counter.
// The counter decides when the debounced level may follow the synchronized input.
module db_channel
  import io_cond_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic i_clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_deb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             s1_q;
  logic             s2_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle where the input agrees with the level discards a partial count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (s2_q == deb_q) begin
      cnt_d = '0;
    end else if (i_tick) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= i_raw;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_deb = deb_q;

endmodule

// File: rtl/io_input_cond.sv
// Conditions the board switches and buttons for the CPU: synchronize, debounce,
// and produce registered edge pulses. One prescaler paces all 36 channels.
module io_input_cond
  import io_cond_pkg::*;
#(
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int STABLE_TICKS   = DEF_STABLE_TICKS,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic             i_clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  i_sw_raw,
  input  logic [N_BTN-1:0] i_btn_raw,
  output logic [N_SW-1:0]  o_sw,
  output logic [N_BTN-1:0] o_btn,
  output logic [N_BTN-1:0] o_btn_press,
  output logic [N_BTN-1:0] o_btn_release,
  output logic             o_sw_chg
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic             tick;
  logic [N_CH-1:0]  raw_ch;
  logic [N_CH-1:0]  deb_ch;

  logic [N_SW-1:0]  sw_prev_q;
  logic [N_BTN-1:0] btn_prev_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] release_q;
  logic [N_BTN-1:0] release_d;
  logic             chg_q;
  logic             chg_d;

  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

  // Buttons are normalised to active-high before they reach the synchronizers.
  assign raw_ch = {i_btn_raw ^ {N_BTN{BTN_ACTIVE_LOW}}, i_sw_raw};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    db_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .i_clk (i_clk),
      .rst   (rst),
      .i_tick(tick),
      .i_raw (raw_ch[g]),
      .o_deb (deb_ch[g])
    );
  end

  // Edges are found against a one-cycle-old copy of the debounced levels.
  always_comb begin
    press_d   = deb_ch[N_CH-1:N_SW] & ~btn_prev_q;
    release_d = ~deb_ch[N_CH-1:N_SW] & btn_prev_q;
    chg_d     = |(deb_ch[N_SW-1:0] ^ sw_prev_q);
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      pre_q      <= '0;
      sw_prev_q  <= '0;
      btn_prev_q <= '0;
      press_q    <= '0;
      release_q  <= '0;
      chg_q      <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      sw_prev_q  <= deb_ch[N_SW-1:0];
      btn_prev_q <= deb_ch[N_CH-1:N_SW];
      press_q    <= press_d;
      release_q  <= release_d;
      chg_q      <= chg_d;
    end
  end

  assign o_sw          = deb_ch[N_SW-1:0];
  assign o_btn         = deb_ch[N_CH-1:N_SW];
  assign o_btn_press   = press_q;
  assign o_btn_release = release_q;
  assign o_sw_chg      = chg_q;

endmodule

// File: tb/tb_io_input_cond.sv
// Scoreboard bench: two instances (tick every cycle, tick every 5 cycles) share the inputs
// and are compared cycle by cycle against a run-length reference model.
module tb_io_input_cond;

  localparam int STABLE = 4;

  typedef struct packed {
    logic [31:0] sw;
    logic [3:0]  btn;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic        chg;
  } outs_t;

  logic        i_clk = 1'b0;
  logic        rst   = 1'b0;
  logic [31:0] swRaw = '0;
  logic [3:0]  btnRaw = 4'hF;

  logic [31:0] aSw, bSw;
  logic [3:0]  aBtn, aPress, aRel, bBtn, bPress, bRel;
  logic        aChg, bChg;

  int checks = 0;
  int errors = 0;

  outs_t expA[$];
  outs_t expB[$];

  int        tickDiv[2] = '{1, 5};
  bit [35:0] lvl[2];
  bit [35:0] lvlPrev[2];
  int        phase[2];
  int        run[2][36];
  bit [35:0] sync0, sync1;

  always #5 i_clk = ~i_clk;

  io_input_cond #(.TICK_DIV(1), .STABLE_TICKS(STABLE), .BTN_ACTIVE_LOW(1'b1)) dutA (
    .i_clk(i_clk), .rst(rst), .i_sw_raw(swRaw), .i_btn_raw(btnRaw),
    .o_sw(aSw), .o_btn(aBtn), .o_btn_press(aPress), .o_btn_release(aRel), .o_sw_chg(aChg));

  io_input_cond #(.TICK_DIV(5), .STABLE_TICKS(STABLE), .BTN_ACTIVE_LOW(1'b1)) dutB (
    .i_clk(i_clk), .rst(rst), .i_sw_raw(swRaw), .i_btn_raw(btnRaw),
    .o_sw(bSw), .o_btn(bBtn), .o_btn_press(bPress), .o_btn_release(bRel), .o_sw_chg(bChg));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // A level is accepted once a mismatch run has spanned STABLE ticks; the synchronizer is a 2-deep delay.
  task automatic modelStep(input bit rstN, input bit [35:0] raw);
    outs_t     e;
    bit [35:0] nl;
    bit        tk;
    for (int m = 0; m < 2; m++) begin
      e = '0;
      if (!rstN) begin
        lvl[m] = '0;
        lvlPrev[m] = '0;
        phase[m] = 0;
        for (int i = 0; i < 36; i++) run[m][i] = 0;
      end else begin
        tk = (phase[m] == tickDiv[m] - 1);
        nl = lvl[m];
        for (int i = 0; i < 36; i++) begin
          if (sync0[i] == lvl[m][i]) run[m][i] = 0;
          else if (tk) begin
            run[m][i]++;
            if (run[m][i] == STABLE) begin
              nl[i] = sync0[i];
              run[m][i] = 0;
            end
          end
        end
        e.press = lvl[m][35:32] & ~lvlPrev[m][35:32];
        e.rel   = ~lvl[m][35:32] & lvlPrev[m][35:32];
        e.chg   = (lvl[m][31:0] != lvlPrev[m][31:0]);
        lvlPrev[m] = lvl[m];
        lvl[m]     = nl;
        phase[m]   = tk ? 0 : phase[m] + 1;
        e.sw  = nl[31:0];
        e.btn = nl[35:32];
      end
      if (m == 0) expA.push_back(e);
      else expB.push_back(e);
    end
    if (!rstN) begin
      sync0 = '0;
      sync1 = '0;
    end else begin
      sync0 = sync1;
      sync1 = raw;
    end
  endtask

  task automatic applyStimulus(input bit rstN, input logic [31:0] sw, input logic [3:0] btn);
    @(negedge i_clk);
    rst    = rstN;
    swRaw  = sw;
    btnRaw = btn;
    modelStep(rstN, {~btn, sw});
  endtask

  task automatic holdFor(input int n, input logic [31:0] sw, input logic [3:0] btn);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, sw, btn);
  endtask

  initial begin : monitor
    outs_t ea;
    outs_t eb;
    forever begin
      @(posedge i_clk);
      #1;
      if (expA.size() != 0) begin
        ea = expA.pop_front();
        checkOutput("A.sw", aSw, ea.sw);
        checkOutput("A.btn", {28'd0, aBtn}, {28'd0, ea.btn});
        checkOutput("A.press", {28'd0, aPress}, {28'd0, ea.press});
        checkOutput("A.release", {28'd0, aRel}, {28'd0, ea.rel});
        checkOutput("A.sw_chg", {31'd0, aChg}, {31'd0, ea.chg});
      end
      if (expB.size() != 0) begin
        eb = expB.pop_front();
        checkOutput("B.sw", bSw, eb.sw);
        checkOutput("B.btn", {28'd0, bBtn}, {28'd0, eb.btn});
        checkOutput("B.press", {28'd0, bPress}, {28'd0, eb.press});
        checkOutput("B.release", {28'd0, bRel}, {28'd0, eb.rel});
        checkOutput("B.sw_chg", {31'd0, bChg}, {31'd0, eb.chg});
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int          pulses;
    int          glitchSeen;
    logic [31:0] curSw;
    logic [3:0]  curBtn;
    bit          rn;

    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'h0, 4'hF);
    checkOutput("reset_sw", aSw, 32'h0);
    checkOutput("reset_btn", {28'd0, aBtn}, 32'h0);
    holdFor(4, 32'h0, 4'hF);

    // Switch step: still 0 after 5 edges, accepted on the 6th, one change pulse.
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, 32'h0000_00A5, 4'hF);
      if (k == 6) checkOutput("sw_step_early", aSw, 32'h0);
      if (k == 7) checkOutput("sw_step_edge6", aSw, 32'h0000_00A5);
      pulses += int'(aChg);
    end
    checkOutput("sw_step_chg_count", pulses, 1);
    holdFor(30, 32'h0000_00A5, 4'hF);
    holdFor(30, 32'h0, 4'hF);

    // Bits 0 and 31 together: a single change pulse.
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, 32'h8000_0001, 4'hF);
      pulses += int'(aChg);
    end
    checkOutput("dual_bit_chg_count", pulses, 1);
    checkOutput("dual_bit_value", aSw, 32'h8000_0001);
    holdFor(25, 32'h8000_0001, 4'hF);

    // Two-cycle glitch on active-low button 0 must never be accepted.
    glitchSeen = 0;
    for (int k = 1; k <= 14; k++) begin
      applyStimulus(1'b1, 32'h8000_0001, (k == 2 || k == 3) ? 4'hE : 4'hF);
      glitchSeen += int'(aBtn[0] | aPress[0] | aRel[0]);
    end
    checkOutput("btn_glitch_ignored", glitchSeen, 0);

    // Button 2 pressed for 10 cycles, then released.
    holdFor(10, 32'h8000_0001, 4'hB);
    holdFor(30, 32'h8000_0001, 4'hF);

    // Reset while sw bit 3 is mid-count, then re-qualification from scratch.
    holdFor(30, 32'h0, 4'hF);
    holdFor(4, 32'h8, 4'hF);
    applyStimulus(1'b0, 32'h8, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 32'h8, 4'hF);
      if (k == 1) checkOutput("midcount_reset_sw", aSw, 32'h0);
      if (k == 6) checkOutput("requalify_early", {31'd0, aSw[3]}, 32'h0);
      if (k == 7) checkOutput("requalify_edge6", {31'd0, aSw[3]}, 32'h1);
    end
    holdFor(25, 32'h8, 4'hF);

    // Randomized traffic with sparse bit flips, bursts and occasional resets.
    curSw  = 32'h8;
    curBtn = 4'hF;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) curSw[$urandom_range(0, 31)] = ~curSw[$urandom_range(0, 31)];
      if ($urandom_range(0, 29) == 0) curSw = curSw ^ $urandom();
      if ($urandom_range(0, 7) == 0) curBtn[$urandom_range(0, 3)] = ~curBtn[$urandom_range(0, 3)];
      rn = ($urandom_range(0, 149) != 0);
      applyStimulus(rn, curSw, curBtn);
    end
    holdFor(40, curSw, curBtn);

    @(posedge i_clk);
    #2;
    checkOutput("queue_drained", expA.size() + expB.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
